// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding and the default operand width.
// Contents    : DEFAULT_WIDTH       default operand/sum width
//               IDLE, SHIFT, DONE   2-bit state encodings
//               state_t             state register type
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand and sum width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding. The encoding is fixed so that other blocks and
    // debug tools can decode the state register directly.
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : Purely combinational one-bit full adder. The serial adder
//               reuses one instance of this cell for every bit position.
// Ports       : a     in   1  addend bit A
//               b     in   1  addend bit B
//               cin   in   1  carry in
//               s     out  1  sum bit, a ^ b ^ cin
//               cout  out  1  carry out, majority(a, b, cin)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;  // propagate
    logic w_g;  // generate

    assign w_p  = a ^ b;
    assign w_g  = a & b;
    assign s    = w_p ^ cin;
    assign cout = w_g | (w_p & cin);

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial ripple adder. Accepts two WIDTH-bit operands and
//               a carry-in on a valid/ready port, adds them LSB first through
//               a single full-adder cell over WIDTH cycles, then presents the
//               result on a valid/ready output port until it is accepted.
// Parameters  : WIDTH      operand and sum width in bits (>= 1)
// Ports       : clk        in   1      clock, rising edge
//               rst        in   1      asynchronous active-high reset
//               in_valid   in   1      operands valid
//               in_ready   out  1      block can accept operands
//               a          in   WIDTH  operand A
//               b          in   WIDTH  operand B
//               cin        in   1      carry in
//               out_valid  out  1      result valid
//               out_ready  in   1      consumer accepts result
//               sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//               cout       out  1      bit WIDTH of a + b + cin
//               busy       out  1      operation in progress (SHIFT or DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter is wide enough to hold WIDTH itself.
    localparam int              CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next_state;

    logic [WIDTH-1:0]  r_a_sr;
    logic [WIDTH-1:0]  r_b_sr;
    logic [WIDTH-1:0]  r_sum_sr;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;

    // Full-adder cell results for the current bit position
    logic              w_fa_s;
    logic              w_fa_c;

    // Sum register after inserting the new bit at the MSB
    logic [WIDTH-1:0]  w_sum_shift;

    logic              w_accept;
    logic              w_last_bit;

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_last_bit = (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------
    // The single full-adder cell, fed from the LSBs of the operand shift
    // registers and the carry flop.
    // ------------------------------------------------------------------
    full_adder_cell u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_c)
    );

    // Sum bits enter at the MSB and move right, so after WIDTH shifts the
    // first (LSB) result bit has arrived at position 0. A one-bit adder has
    // nothing to shift, so it simply takes the new bit.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_shift = w_fa_s;
        end else begin : g_sum_wn
            assign w_sum_shift = {w_fa_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                // Leave on the edge that processes the final bit.
                if (w_last_bit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, decoded from registered state only (apart
    // from the reset term that holds in_ready low during reset).
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        // The result registers are untouched in DONE and IDLE, so the
        // outputs stay stable while valid and hold afterwards.
        sum       = r_sum_sr;
        cout      = r_carry;
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, carry flop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_sum_sr <= '0;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_shift;
                    r_carry  <= w_fa_c;
                    r_cnt    <= r_cnt + C_CNT_ONE;
                end
                default: begin
                    // DONE: hold the result for the consumer.
                end
            endcase
        end
    end

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. An 8-bit instance is
//               exercised with a vector table, backpressure, mid-operation
//               reset and back-to-back traffic; a 1-bit instance is swept
//               through the full-adder truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    // 8-bit instance
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0] a, b, sum;

    // 1-bit instance
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic         a1, b1, cin1, sum1, cout1, busy1;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for the 8-bit instance. Handshakes are judged at the
    // negedge for the following rising edge.
    // ------------------------------------------------------------------
    logic [W:0] sb_q[$];
    int         acc_cyc = 0;
    logic       prev_ov = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                check("spurious_result", sb_q.size() == 0, 0);
                check("latency", cyc - acc_cyc, W);
            end
            if (out_valid && out_ready && sb_q.size() > 0) begin
                check("sb_sum",  sum,  sb_q[0][W-1:0]);
                check("sb_cout", cout, sb_q[0][W]);
                sb_q.delete(0);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                acc_cyc <= cyc + 1;
            end
            prev_ov <= out_valid;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic [W-1:0] r_res_sum;
    logic         r_res_cout;

    task automatic wait_in_ready(input string name);
        bit got = 0;
        for (int i = 0; i < 4 * W + 10 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        if (!got) timeout(name);
    endtask

    task automatic wait_out_valid(input string name);
        bit got = 0;
        for (int i = 0; i < W + 5 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) timeout(name);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        wait_in_ready("accept_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid("result_wait");
        r_res_sum  = sum;
        r_res_cout = cout;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int prev_acc;
        int this_acc;
        logic [1:0] fa_exp;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

        rst = 1'b1;
        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum",       sum,       0);
        check("rst_cout",      cout,      0);
        check("rst_busy",      busy,      0);
        check("rst_in_ready1", in_ready1, 0);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready",  in_ready,  1);
        check("post_rst_in_ready1", in_ready1, 1);

        // Vector table
        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin);
            check($sformatf("tbl%0d_sum", i),  r_res_sum,  tbl[i].s);
            check($sformatf("tbl%0d_cout", i), r_res_cout, tbl[i].co);
        end

        // Backpressure: 0x55 + 0x0F = 0x64
        @(posedge clk); #1;
        a = 8'h55; b = 8'h0F; cin = 0; in_valid = 1'b1; out_ready = 1'b0;
        wait_in_ready("bp_accept");
        @(posedge clk); #1;
        for (int i = 0; i < W + 8; i++) begin
            in_valid = i[0];
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            if (out_valid) break;
        end
        if (!out_valid) timeout("bp_result");
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready",  in_ready,  0);
            check("bp_sum",       sum,       8'h64);
            check("bp_cout",      cout,      0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready",  in_ready,  1);
        repeat (W + 3) @(posedge clk);
        #1;
        check("bp_no_extra_result", out_valid, 0);
        check("bp_queue_empty", sb_q.size(), 0);

        // Reset during SHIFT
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; cin = 0; in_valid = 1'b1; out_ready = 1'b1;
        wait_in_ready("rst_op_accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum",       sum,       0);
        check("midrst_cout",      cout,      0);
        check("midrst_busy",      busy,      0);
        check("midrst_in_ready",  in_ready,  0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        repeat (W + 3) @(posedge clk);
        #1;
        check("midrst_no_result", out_valid, 0);
        do_op(8'h12, 8'h34, 1'b0);
        check("midrst_next_sum",  r_res_sum,  8'h46);
        check("midrst_next_cout", r_res_cout, 0);

        // WIDTH=1 truth table, one-cycle latency
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            a1 = k[2]; b1 = k[1]; cin1 = k[0];
            in_valid1 = 1'b1; out_ready1 = 1'b1;
            fa_exp = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            check("w1_in_ready", in_ready1, 1);
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            check("w1_shift_no_valid", out_valid1, 0);
            @(posedge clk); #1;
            check("w1_out_valid", out_valid1, 1);
            check($sformatf("w1_sum_%0d", k),  sum1,  fa_exp[0]);
            check($sformatf("w1_cout_%0d", k), cout1, fa_exp[1]);
        end

        // Back-to-back with in_valid and out_ready held high
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        prev_acc = 0;
        for (int k = 0; k < 10; k++) begin
            wait_in_ready("b2b_accept");
            this_acc = cyc + 1;
            if (k > 0) check("b2b_spacing", this_acc - prev_acc, W + 2);
            prev_acc = this_acc;
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        end
        in_valid = 1'b0;
        begin
            bit drained = 0;
            for (int i = 0; i < 3 * W && !drained; i++) begin
                @(negedge clk);
                if (sb_q.size() == 0 && !out_valid) drained = 1;
            end
            if (!drained) timeout("b2b_drain");
        end
        check("final_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
